// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-address width and stage control-word width.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int CTRL_WIDTH = 16;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // True when a used source register matches the producer's destination.
  function automatic logic reg_hit(input logic [REG_ADDR_W-1:0] rs,
                                   input logic                  used,
                                   input logic [REG_ADDR_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage-register enables/flushes and status out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  import pipe_pkg::*;

  logic [REG_ADDR_W-1:0] q2_rs1_i;
  logic [REG_ADDR_W-1:0] q2_rs2_i;
  logic                  q2_rs1_used_i;
  logic                  q2_rs2_used_i;
  logic [REG_ADDR_W-1:0] q3_rd_i;
  logic                  q3_mem_read_i;
  logic                  q3_branch_taken_i;
  logic                  dmem_req_i;
  logic                  dmem_ready_i;
  logic                  stall_cnt_clr_i;

  logic                  pc_en_o;
  logic                  q1q2_en_o;
  logic                  q2q3_en_o;
  logic                  q3q4_en_o;
  logic                  q4q5_en_o;
  logic                  q1q2_flush_o;
  logic                  q2q3_flush_o;
  logic                  q3q4_flush_o;
  logic                  q4q5_flush_o;
  logic                  mem_err_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;

  modport master (
    output q2_rs1_i, q2_rs2_i, q2_rs1_used_i, q2_rs2_used_i,
           q3_rd_i, q3_mem_read_i, q3_branch_taken_i,
           dmem_req_i, dmem_ready_i, stall_cnt_clr_i,
    input  pc_en_o, q1q2_en_o, q2q3_en_o, q3q4_en_o, q4q5_en_o,
           q1q2_flush_o, q2q3_flush_o, q3q4_flush_o, q4q5_flush_o,
           mem_err_o, stall_cnt_o
  );

  modport slave (
    input  q2_rs1_i, q2_rs2_i, q2_rs1_used_i, q2_rs2_used_i,
           q3_rd_i, q3_mem_read_i, q3_branch_taken_i,
           dmem_req_i, dmem_ready_i, stall_cnt_clr_i,
    output pc_en_o, q1q2_en_o, q2q3_en_o, q3q4_en_o, q4q5_en_o,
           q1q2_flush_o, q2q3_flush_o, q3q4_flush_o, q4q5_flush_o,
           mem_err_o, stall_cnt_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment, holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > taken branch > load-use.
// Enables/flushes are combinational so a stall acts in the cycle it is detected.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int WCNT_W = 16;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              mem_err;

  logic mem_stall;
  logic load_use;

  logic pc_en, en12, en23, en34, en45;
  logic fl12, fl23, fl34, fl45;

  assign mem_stall = hz.dmem_req_i & ~hz.dmem_ready_i;

  assign load_use = hz.q3_mem_read_i && (hz.q3_rd_i != '0) &&
                    (reg_hit(hz.q2_rs1_i, hz.q2_rs1_used_i, hz.q3_rd_i) ||
                     reg_hit(hz.q2_rs2_i, hz.q2_rs2_used_i, hz.q3_rd_i));

  always_comb begin
    pc_en = 1'b1;
    en12  = 1'b1;
    en23  = 1'b1;
    en34  = 1'b1;
    en45  = 1'b1;
    fl12  = 1'b0;
    fl23  = 1'b0;
    fl34  = 1'b0;
    fl45  = 1'b0;
    if (mem_stall) begin
      // Freeze Q1..Q4 so any pending branch/load-use inputs stay stable; WB gets a bubble.
      pc_en = 1'b0;
      en12  = 1'b0;
      en23  = 1'b0;
      en34  = 1'b0;
      fl45  = 1'b1;
    end else if (hz.q3_branch_taken_i) begin
      fl12 = 1'b1;
      fl23 = 1'b1;
    end else if (load_use) begin
      pc_en = 1'b0;
      en12  = 1'b0;
      fl23  = 1'b1;
    end
  end

  assign hz.pc_en_o      = pc_en & rst_n;
  assign hz.q1q2_en_o    = en12  & rst_n;
  assign hz.q2q3_en_o    = en23  & rst_n;
  assign hz.q3q4_en_o    = en34  & rst_n;
  assign hz.q4q5_en_o    = en45  & rst_n;
  assign hz.q1q2_flush_o = fl12  & rst_n;
  assign hz.q2q3_flush_o = fl23  & rst_n;
  assign hz.q3q4_flush_o = fl34  & rst_n;
  assign hz.q4q5_flush_o = fl45  & rst_n;
  assign hz.mem_err_o    = mem_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wait_cnt <= '0;
          if (mem_stall) begin
            state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (!hz.dmem_req_i || hz.dmem_ready_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WCNT_LAST) begin
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.stall_cnt_clr_i),
    .inc   (~hz.pc_en_o),
    .cnt   (hz.stall_cnt_o)
  );

endmodule
